// File: rtl/fetch_unit_pkg.sv
// Shared core definitions: fetch FSM encoding, reset PC default and the
// opcode/mode constants that decide whether an instruction carries a k16 word.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [1:0]  MODE_NO_EXT      = 2'b00;
    localparam logic [4:0]  OPC_NO_EXT       = 5'b11111;

    // Decided from the opcode word alone; the decoder uses the same rule.
    function automatic logic needs_ext(input logic [15:0] word);
        return (word[5:4] != MODE_NO_EXT) && (word[15:11] != OPC_NO_EXT);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read bus: one outstanding request, held until acknowledged.
interface fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// Instruction-word FIFO: one push per cycle, pops 0/1/2 words, exposes the
// head and the word behind it so an opcode and its extension can leave together.
module fetch_queue #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [15:0]   push_data,
    input  logic [1:0]    pop_n,
    output logic [15:0]   head,
    output logic [15:0]   second,
    output logic [CW-1:0] count
);
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + CW'(push) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding read FSM filling a word queue, and
// presentation of whole (one- or two-word) instructions to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    fetch_unit_if.master        mem,
    output logic [15:0]         ir,
    output logic [15:0]         ir_ext,
    output logic                ir_valid,
    output logic [15:0]         ir_pc,
    input  logic                feed_ack,
    input  logic                pc_inv,
    input  logic [15:0]         redirect_pc
);
    fetch_state_t  state;
    logic [15:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          ext_needed;
    logic          pop_fire;
    logic [1:0]    pop_n;
    logic          push;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (pc_inv),
        .push      (push),
        .push_data (mem.mem_rdata),
        .pop_n     (pop_n),
        .head      (ir),
        .second    (ir_ext),
        .count     (count)
    );

    assign ext_needed  = needs_ext(ir);
    assign ir_valid    = ext_needed ? (count >= CW'(2)) : (count >= CW'(1));
    assign pop_fire    = feed_ack && ir_valid && !hold && !pc_inv;
    assign pop_n       = pop_fire ? (ext_needed ? 2'd2 : 2'd1) : 2'd0;
    assign push        = (state == ST_WAIT) && mem.mem_ack && !pc_inv;
    // Occupancy after this cycle's push/pop decides whether another read may start.
    assign count_after = count + CW'(push) - CW'(pop_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= RESET_PC;
            fetch_pc     <= RESET_PC;
            ir_pc        <= RESET_PC;
        end else begin
            if (pc_inv)        ir_pc <= redirect_pc;
            else if (pop_fire) ir_pc <= ir_pc + 16'(pop_n);

            case (state)
                ST_IDLE: begin
                    if (pc_inv) begin
                        fetch_pc <= redirect_pc;
                    end else if (count_after < CW'(DEPTH)) begin
                        state        <= ST_WAIT;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= fetch_pc;
                    end
                end
                ST_WAIT: begin
                    if (pc_inv) begin
                        fetch_pc <= redirect_pc;
                        if (mem.mem_ack) begin
                            state       <= ST_IDLE;
                            mem.mem_req <= 1'b0;
                        end else begin
                            // Request already on the bus; let it finish and discard it.
                            state <= ST_DROP;
                        end
                    end else if (mem.mem_ack) begin
                        fetch_pc <= fetch_pc + 16'd1;
                        if (count_after < CW'(DEPTH)) begin
                            mem.mem_addr <= fetch_pc + 16'd1;
                        end else begin
                            state       <= ST_IDLE;
                            mem.mem_req <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (pc_inv) fetch_pc <= redirect_pc;
                    if (mem.mem_ack) begin
                        state       <= ST_IDLE;
                        mem.mem_req <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory handshake, queue fill/drain, extension
// words, hold, redirects with and without a racing ack, and address wrap.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [15:0] ir;
    logic [15:0] ir_ext;
    logic        ir_valid;
    logic [15:0] ir_pc;
    logic        feed_ack;
    logic        pc_inv;
    logic [15:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .mem         (bus.master),
        .ir          (ir),
        .ir_ext      (ir_ext),
        .ir_valid    (ir_valid),
        .ir_pc       (ir_pc),
        .feed_ack    (feed_ack),
        .pc_inv      (pc_inv),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ack_word(input logic [15:0] data);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        tick();
        bus.mem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; feed_ack = 1'b0; pc_inv = 1'b0; redirect_pc = 16'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
        tick(); tick();
        chk("rst_req", 16'(bus.mem_req), 16'h0);
        chk("rst_valid", 16'(ir_valid), 16'h0);
        chk("rst_addr", bus.mem_addr, 16'h0000);
        chk("rst_irpc", ir_pc, 16'h0000);

        // First request one cycle after reset release, then back-to-back acks
        rst = 1'b0;
        tick();
        chk("first_req", 16'(bus.mem_req), 16'h1);
        chk("first_addr", bus.mem_addr, 16'h0000);
        ack_word(16'h1000);
        chk("w0_valid", 16'(ir_valid), 16'h1);
        chk("w0_ir", ir, 16'h1000);
        chk("w0_irpc", ir_pc, 16'h0000);
        chk("w0_addr", bus.mem_addr, 16'h0001);
        ack_word(16'h1001);
        chk("w1_addr", bus.mem_addr, 16'h0002);
        chk("w1_ir", ir, 16'h1000);

        feed_ack = 1'b1;
        tick();
        chk("pop1_ir", ir, 16'h1001);
        chk("pop1_irpc", ir_pc, 16'h0001);
        tick();
        chk("pop2_irpc", ir_pc, 16'h0002);
        chk("pop2_valid", 16'(ir_valid), 16'h0);
        tick();
        chk("ack_ignored_irpc", ir_pc, 16'h0002);
        feed_ack = 1'b0;

        // Two-word instruction: mode 01 head needs its extension before valid
        ack_word(16'h0010);
        chk("ext_wait_valid", 16'(ir_valid), 16'h0);
        ack_word(16'hBEEF);
        chk("ext_valid", 16'(ir_valid), 16'h1);
        chk("ext_word", ir_ext, 16'hBEEF);
        chk("ext_ir", ir, 16'h0010);
        feed_ack = 1'b1;
        tick();
        chk("ext_pop_irpc", ir_pc, 16'h0004);
        chk("ext_pop_valid", 16'(ir_valid), 16'h0);

        // Fill under hold with feed_ack asserted: nothing pops, queue fills
        hold = 1'b1;
        ack_word(16'h2000);
        ack_word(16'h2001);
        ack_word(16'h2002);
        chk("hold_irpc", ir_pc, 16'h0004);
        chk("hold_ir", ir, 16'h2000);
        ack_word(16'h2003);
        chk("full_req", 16'(bus.mem_req), 16'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("full_noreq", 16'(bus.mem_req), 16'h0);
        end
        chk("full_irpc", ir_pc, 16'h0004);
        hold = 1'b0;
        tick();
        feed_ack = 1'b0;
        chk("refill_req", 16'(bus.mem_req), 16'h1);
        chk("refill_addr", bus.mem_addr, 16'h0008);
        chk("refill_ir", ir, 16'h2001);
        chk("refill_irpc", ir_pc, 16'h0005);

        // Redirect while a read is pending: the late word must be dropped
        pc_inv = 1'b1; redirect_pc = 16'h4000;
        tick();
        pc_inv = 1'b0;
        chk("drop_req", 16'(bus.mem_req), 16'h1);
        chk("drop_addr", bus.mem_addr, 16'h0008);
        chk("drop_valid", 16'(ir_valid), 16'h0);
        chk("drop_irpc", ir_pc, 16'h4000);
        tick(); tick();
        ack_word(16'hDEAD);
        chk("drop_done_req", 16'(bus.mem_req), 16'h0);
        chk("drop_done_valid", 16'(ir_valid), 16'h0);
        tick();
        chk("redir_req", 16'(bus.mem_req), 16'h1);
        chk("redir_addr", bus.mem_addr, 16'h4000);
        ack_word(16'h1234);
        chk("redir_ir", ir, 16'h1234);
        chk("redir_irpc", ir_pc, 16'h4000);

        // Redirect racing an ack: data discarded, straight back to idle
        pc_inv = 1'b1; redirect_pc = 16'hFFFE;
        ack_word(16'h5555);
        pc_inv = 1'b0;
        chk("race_req", 16'(bus.mem_req), 16'h0);
        chk("race_valid", 16'(ir_valid), 16'h0);
        chk("race_irpc", ir_pc, 16'hFFFE);
        tick();
        chk("race_addr", bus.mem_addr, 16'hFFFE);

        // Address wrap and a two-word pop straddling 16'hFFFF
        ack_word(16'h1000);
        chk("wrap_addr_ffff", bus.mem_addr, 16'hFFFF);
        ack_word(16'h0020);
        chk("wrap_addr_0", bus.mem_addr, 16'h0000);
        ack_word(16'hBEEF);
        feed_ack = 1'b1;
        tick();
        chk("wrap_irpc_ffff", ir_pc, 16'hFFFF);
        chk("wrap_ext", ir_ext, 16'hBEEF);
        tick();
        feed_ack = 1'b0;
        chk("wrap_irpc_1", ir_pc, 16'h0001);

        // Opcode 11111 never takes an extension even with a nonzero mode
        ack_word(16'hF810);
        chk("noext_opc_valid", 16'(ir_valid), 16'h1);

        // Reset during a pending read abandons it without draining
        rst = 1'b1;
        tick();
        chk("midrst_req", 16'(bus.mem_req), 16'h0);
        chk("midrst_valid", 16'(ir_valid), 16'h0);
        rst = 1'b0;
        tick();
        chk("midrst_restart", 16'(bus.mem_req), 16'h1);
        chk("midrst_addr", bus.mem_addr, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-word queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 hold  in  1  pipeline stall; blocks queue pop, fetch continues.
REQ-007 mem_req  out  1  word read request, held until mem_ack.
REQ-008 mem_addr  out  16  word address of the pending request.
REQ-009 mem_ack  in  1  read complete; mem_rdata valid this cycle.
REQ-010 mem_rdata  in  16  returned instruction word.
REQ-011 ir  out  16  queue head word (opcode word) to decode.
REQ-012 ir_ext  out  16  queue second word (k16 extension).
REQ-013 ir_valid  out  1  head instruction complete in queue.
REQ-014 ir_pc  out  16  word address of ir.
REQ-015 feed_ack  in  1  decode consumed the presented instruction.
REQ-016 pc_inv  in  1  redirect: flush queue, refetch from redirect_pc.
REQ-017 redirect_pc  in  16  new instruction address, sampled when pc_inv=1.

Function
REQ-018 ext_needed SHALL equal (ir[5:4]!=2'b00) and (ir[15:11]!=5'b11111), computed from the head word only.
REQ-019 ir_valid SHALL be count>=1 when ext_needed=0, count>=2 when ext_needed=1; ir/ir_ext/ir_pc SHALL be don't-care when ir_valid=0.
REQ-020 A pop SHALL occur when feed_ack & ir_valid & ~hold & ~pc_inv; it removes 1 word (ext_needed=0) or 2 words (ext_needed=1) and adds the same to ir_pc, mod 2^16.
REQ-021 feed_ack with ir_valid=0 SHALL be ignored.
REQ-022 Fetch FSM states: IDLE, WAIT, DROP.
REQ-023 IDLE->WAIT when count plus zero in-flight < DEPTH: assert mem_req with mem_addr=fetch_pc.
REQ-024 WAIT: mem_req=1, mem_addr stable; on mem_ack push mem_rdata, fetch_pc+=1 (wraps 16'hFFFF->16'h0000), go IDLE, or stay WAIT with the next address in the same cycle if room remains after push and pop.
REQ-025 At most one request SHALL be outstanding.
REQ-026 Push and pop in one cycle SHALL update count by +1-n; a push into a full queue SHALL never happen (request gated in REQ-023).
REQ-027 pc_inv SHALL, next cycle: count=0, ir_pc=redirect_pc, fetch_pc=redirect_pc; pc_inv has priority over pop and push in that cycle.
REQ-028 pc_inv in WAIT without mem_ack SHALL go DROP: mem_req stays 1 at old mem_addr until mem_ack, data discarded, then IDLE.
REQ-029 pc_inv in WAIT with mem_ack in the same cycle SHALL discard that data and go IDLE.
REQ-030 pc_inv in DROP SHALL only update fetch_pc/ir_pc; state stays DROP.
REQ-031 Steady-state latency: first mem_req one cycle after rst falls; with mem_ack same-cycle, ir_valid rises the cycle after the required words are pushed.

Reset
REQ-032 On rst: state=IDLE, count=0, mem_req=0, ir_valid=0, fetch_pc=RESET_PC, ir_pc=RESET_PC, mem_addr=RESET_PC.
REQ-033 rst mid-WAIT SHALL abandon the request; the memory side tolerates the drop, no DROP state is entered.

Structure
REQ-034 Fetch FSM state encoding, RESET_PC default and the ext_needed opcode/mode constants (5'b11111, 2'b00) SHALL live in the shared core package used by the decoder.
REQ-035 The queue SHALL be a sub-module fetch_queue (DEPTH x 16, push 1, pop 0/1/2, count output); the FSM and PCs stay in fetch_unit.

Verification
REQ-036 Reset release, mem_ack every WAIT cycle, words 16'h1000,16'h1001 -> mem_addr 0,1,2...; ir=16'h1000, ir_valid=1, ir_pc=0 one cycle after first push.
REQ-037 Head 16'h0010 (mode 01) with one word queued -> ir_valid=0; after ext word 16'hBEEF pushed -> ir_valid=1, ir_ext=16'hBEEF; feed_ack -> ir_pc+=2.
REQ-038 mem_ack withheld 8 cycles with queue full (DEPTH=4) -> no mem_req while count=4; single pop -> mem_req next cycle.
REQ-039 pc_inv with redirect_pc=16'h4000 in WAIT, mem_ack 3 cycles later -> returned word not visible, next mem_addr=16'h4000, ir_pc=16'h4000.
REQ-040 fetch_pc=16'hFFFF -> next mem_addr=16'h0000; pop at ir_pc=16'hFFFF with ext word -> ir_pc=16'h0001.
REQ-041 hold=1 with feed_ack=1, ir_valid=1 for 3 cycles -> count and ir_pc unchanged, fetch fills to DEPTH.
